// File: rtl/cpu_boot_pkg.sv
// Shared definitions for the MIPS bring-up controller: FSM state encoding,
// load-target codes and the common address-width helper.
package cpu_boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_CLEAR = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_HOLD  = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic TGT_IM = 1'b0;
  localparam logic TGT_DM = 1'b1;

  // Word-address width wide enough for the larger of the two memories.
  function automatic int addr_w(input int im_depth, input int dm_depth);
    int d;
    d = (im_depth > dm_depth) ? im_depth : dm_depth;
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Image load port: a valid/ready stream of (target, address, data, last) words
// from the bench or host UART bridge into the bring-up controller.
interface cpu_boot_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
);
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_target;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_valid, ld_target, ld_addr, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_target, ld_addr, ld_data, ld_last,
    output ld_ready
  );
endinterface

// File: rtl/cpu_boot_ctrl_pc_halt_detect.sv
// Halt detector: flags when the core fetch PC has stayed unchanged long enough
// (stable counter reaches HALT_STABLE-1) while enabled.
module pc_halt_detect #(
  parameter int PC_W        = 32,
  parameter int HALT_STABLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            hit
);
  localparam int CW = $clog2(HALT_STABLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(HALT_STABLE - 1);

  logic [PC_W-1:0] prev_pc_reg;
  logic [CW-1:0]   stable_cnt_reg;

  // prev_pc tracks the PC even while disabled so the first enabled compare
  // sees the value from the cycle before the run started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc_reg    <= '0;
      stable_cnt_reg <= '0;
    end else begin
      prev_pc_reg <= pc;
      if (!en || (pc != prev_pc_reg))
        stable_cnt_reg <= '0;
      else if (stable_cnt_reg != CNT_MAX)
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
    end
  end

  assign hit = en && (stable_cnt_reg == CNT_MAX);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Bring-up controller: zero-fills DM, streams the image into IM/DM, holds the
// core in reset, then runs it until PC halt or the cycle limit.
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IM_DEPTH    = 128,
  parameter int DM_DEPTH    = 128,
  parameter int PC_W        = 32,
  parameter int RST_CYCLES  = 2,
  parameter int HALT_STABLE = 4,
  parameter int MAX_CYCLES  = 20,
  localparam int AW         = addr_w(IM_DEPTH, DM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  cpu_boot_ctrl_if.slave    ld,
  output logic              im_we,
  output logic              dm_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic [31:0]       run_cycles,
  output logic              halted,
  output logic              timeout,
  output logic              done,
  output logic              ld_err
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [AW:0]   CLR_END  = (AW+1)'(DM_DEPTH);
  localparam logic [HW-1:0] HOLD_END = HW'(RST_CYCLES - 1);

  state_t        state_reg;
  logic [AW:0]   clr_cnt_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic          halt_hit;
  logic          handshake;
  logic          addr_ok;
  logic [31:0]   addr_ext;

  assign ld.ld_ready = (state_reg == ST_LOAD);
  assign handshake   = ld.ld_valid && ld.ld_ready;
  assign addr_ext    = 32'(ld.ld_addr);
  assign addr_ok     = (ld.ld_target == TGT_DM) ? (addr_ext < 32'(DM_DEPTH))
                                                : (addr_ext < 32'(IM_DEPTH));

  pc_halt_detect #(
    .PC_W        (PC_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt (
    .clk (clk),
    .rst (rst),
    .en  (state_reg == ST_RUN),
    .pc  (cpu_pc),
    .hit (halt_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      im_we        <= 1'b0;
      dm_we        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      run_cycles   <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      done         <= 1'b0;
      ld_err       <= 1'b0;
    end else begin
      im_we <= 1'b0;
      dm_we <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (clr_cnt_reg == CLR_END) begin
            state_reg <= ST_LOAD;
          end else begin
            dm_we       <= 1'b1;
            mem_addr    <= clr_cnt_reg[AW-1:0];
            mem_wdata   <= '0;
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            mem_addr  <= ld.ld_addr;
            mem_wdata <= ld.ld_data;
            if (addr_ok) begin
              im_we <= (ld.ld_target == TGT_IM);
              dm_we <= (ld.ld_target == TGT_DM);
            end else begin
              ld_err <= 1'b1;
            end
            if (ld.ld_last) begin
              state_reg    <= ST_HOLD;
              hold_cnt_reg <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt_reg == HOLD_END) begin
            state_reg <= ST_RUN;
            cpu_rst   <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          // Halt wins a tie with the cycle limit; run_cycles freezes on detection.
          if (halt_hit) begin
            halted    <= 1'b1;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else if (run_cycles >= 32'(MAX_CYCLES)) begin
            timeout   <= 1'b1;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else if (run_cycles != 32'hFFFF_FFFF) begin
            run_cycles <= run_cycles + 32'd1;
          end
        end
        ST_DONE: ;
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: randomized images and PC traces checked
// against an arithmetic reference model of clear, load, hold and run phases.
module tb_cpu_boot_ctrl;
  localparam int DATA_W      = 32;
  localparam int IM_DEPTH    = 256;
  localparam int DM_DEPTH    = 128;
  localparam int PC_W        = 32;
  localparam int RST_CYCLES  = 2;
  localparam int HALT_STABLE = 4;
  localparam int MAX_CYCLES  = 20;
  localparam int AW          = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_boot_ctrl_if #(.DATA_W(DATA_W), .AW(AW)) ld ();

  logic              im_we, dm_we, cpu_rst, halted, timeout, done, ld_err;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [PC_W-1:0]   cpu_pc;
  logic [31:0]       run_cycles;

  cpu_boot_ctrl #(
    .DATA_W(DATA_W), .IM_DEPTH(IM_DEPTH), .DM_DEPTH(DM_DEPTH), .PC_W(PC_W),
    .RST_CYCLES(RST_CYCLES), .HALT_STABLE(HALT_STABLE), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .ld(ld),
    .im_we(im_we), .dm_we(dm_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .cpu_pc(cpu_pc), .run_cycles(run_cycles),
    .halted(halted), .timeout(timeout), .done(done), .ld_err(ld_err)
  );

  int checks = 0;
  int errors = 0;

  // Memories as seen through the write strobes, and the image the bench expects.
  logic [31:0] obs_im [IM_DEPTH];
  logic [31:0] obs_dm [DM_DEPTH];
  logic [31:0] exp_im [IM_DEPTH];
  logic [31:0] exp_dm [DM_DEPTH];
  bit          im_set [IM_DEPTH];
  bit          exp_err;
  int          bad_strobe = 0;

  always @(negedge clk) begin
    if (im_we) obs_im[mem_addr] = mem_wdata;
    if (dm_we) begin
      if (int'(mem_addr) >= DM_DEPTH) bad_strobe++;
      else obs_dm[mem_addr[6:0]] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_and_clear();
    int n, good, pulses;
    rst = 1'b1;
    ld.ld_valid = 1'b0; ld.ld_last = 1'b0; ld.ld_target = 1'b0;
    ld.ld_addr = '0; ld.ld_data = '0;
    cpu_pc = '0;
    for (int i = 0; i < IM_DEPTH; i++) begin obs_im[i] = 'x; im_set[i] = 1'b0; end
    for (int i = 0; i < DM_DEPTH; i++) begin obs_dm[i] = 'x; exp_dm[i] = '0; end
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_flags", {im_we, dm_we, halted, timeout, done, ld_err, ld.ld_ready}, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    n = 0; good = 0; pulses = 0;
    for (int c = 1; c <= DM_DEPTH + 10 && !ld.ld_ready; c++) begin
      @(negedge clk);
      if (dm_we) pulses++;
      if (dm_we && mem_wdata == '0 && int'(mem_addr) == good) good++;
      n = c;
    end
    chk("clear_pulses", pulses, DM_DEPTH);
    chk("clear_in_order", good, DM_DEPTH);
    chk("clear_ready_cycle", n, DM_DEPTH + 1);
  endtask

  // Called at a negedge; returns at the negedge of the strobe cycle.
  task automatic load_word(input logic tgt, input int addr, input logic [31:0] data, input logic last);
    bit ok;
    ok = tgt ? (addr < DM_DEPTH) : (addr < IM_DEPTH);
    ld.ld_valid = 1'b1; ld.ld_target = tgt; ld.ld_addr = AW'(addr);
    ld.ld_data = data; ld.ld_last = last;
    chk("ld_ready_at_hs", ld.ld_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ld.ld_valid = 1'b0;
    ld.ld_last  = 1'b0;
    if (!ok) exp_err = 1'b1;
    else if (tgt) exp_dm[addr] = data;
    else begin exp_im[addr] = data; im_set[addr] = 1'b1; end
    chk("im_we_strobe", im_we, ok && !tgt);
    chk("dm_we_strobe", dm_we, ok && tgt);
    if (ok) chk("strobe_addr_data", {mem_addr, mem_wdata}, {AW'(addr), data});
    $display("load tgt=%0d addr=%0d data=%08h last=%0d in_range=%0d", tgt, addr, data, last, ok);
    if (last) chk("ld_ready_drop", ld.ld_ready, 0);
  endtask

  task automatic wait_release();
    int n;
    n = 1;
    while (cpu_rst && n < 10) begin @(negedge clk); n++; end
    chk("cpu_rst_fall", n, RST_CYCLES + 1);
  endtask

  task automatic check_mem();
    int mi, md;
    mi = 0; md = 0;
    for (int i = 0; i < IM_DEPTH; i++) if (im_set[i] && obs_im[i] !== exp_im[i]) mi++;
    for (int i = 0; i < DM_DEPTH; i++) if (obs_dm[i] !== exp_dm[i]) md++;
    chk("im_image", mi, 0);
    chk("dm_image", md, 0);
    chk("no_oob_strobe", bad_strobe, 0);
    chk("ld_err", ld_err, exp_err);
  endtask

  // PC climbs 4,8,.. and (if stalls) sticks at 4*k from run index k-1 onward.
  task automatic run_and_check(input int k, input bit stalls);
    int e, done_at;
    bit exp_halt;
    exp_halt = stalls && (k + HALT_STABLE - 1 <= MAX_CYCLES);
    e = exp_halt ? k + HALT_STABLE - 1 : MAX_CYCLES;
    done_at = -1;
    for (int i = 0; i <= MAX_CYCLES + 6; i++) begin
      if (done) begin done_at = i; break; end
      chk("run_cycles_count", run_cycles, i);
      cpu_pc = PC_W'(stalls ? 4 * ((i + 1 < k) ? i + 1 : k) : 4 * (i + 1));
      @(negedge clk);
    end
    chk("done_cycle", done_at, e + 1);
    chk("halted", halted, exp_halt);
    chk("timeout", timeout, !exp_halt);
    chk("run_cycles_final", run_cycles, e);
    repeat (3) begin
      cpu_pc = PC_W'($urandom);
      @(negedge clk);
    end
    chk("done_held", {done, cpu_rst}, 2'b10);
    chk("run_cycles_frozen", run_cycles, e);
    $display("run k=%0d stalls=%0d run_cycles=%0d halted=%0d timeout=%0d", k, stalls, run_cycles, halted, timeout);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full image: IM[0..13] with an overwrite, boundary and out-of-range words.
    reset_and_clear();
    for (int i = 0; i < 14; i++) load_word(1'b0, i, $urandom, 1'b0);
    load_word(1'b0, 3, $urandom, 1'b0);
    load_word(1'b0, IM_DEPTH - 1, $urandom, 1'b0);
    load_word(1'b1, 200, $urandom, 1'b0);
    load_word(1'b1, DM_DEPTH, $urandom, 1'b0);
    load_word(1'b1, DM_DEPTH - 1, $urandom, 1'b0);
    load_word(1'b1, 0, 32'd9, 1'b0);
    load_word(1'b1, 1, 32'd3, 1'b1);
    wait_release();
    check_mem();
    run_and_check($urandom_range(1, 10), 1'b1);

    // Straight-line program: only the cycle limit can end the run.
    reset_and_clear();
    load_word(1'b0, $urandom_range(0, IM_DEPTH - 1), $urandom, 1'b0);
    load_word(1'b1, $urandom_range(0, DM_DEPTH - 1), $urandom, 1'b1);
    wait_release();
    check_mem();
    run_and_check(0, 1'b0);

    // Halt detected in the same cycle the limit is reached.
    reset_and_clear();
    load_word(1'b0, 14, $urandom, 1'b1);
    wait_release();
    run_and_check(MAX_CYCLES - HALT_STABLE + 1, 1'b1);

    // Random stall point, either side of the limit.
    reset_and_clear();
    load_word(1'b1, $urandom_range(0, DM_DEPTH - 1), $urandom, 1'b1);
    wait_release();
    run_and_check($urandom_range(1, 25), 1'b1);

    // Asynchronous reset in the middle of a run.
    reset_and_clear();
    load_word(1'b0, 0, $urandom, 1'b1);
    wait_release();
    for (int i = 0; i < 5; i++) begin
      cpu_pc = PC_W'(4 * (i + 1));
      @(negedge clk);
    end
    chk("mid_run_count", run_cycles, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cpu_rst", cpu_rst, 1);
    chk("async_rst_flags", {im_we, dm_we, halted, timeout, done, ld_err, ld.ld_ready}, 0);
    chk("async_rst_run_cycles", run_cycles, 0);
    $display("async reset mid-run cpu_rst=%0d run_cycles=%0d", cpu_rst, run_cycles);
    reset_and_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
